// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants for the PWM generator
package pwm_pkg;
    localparam int PWM_WIDTH_DEFAULT = 8;
    localparam int PWM_PERIOD = 2 ** PWM_WIDTH_DEFAULT;
endpackage

// File: rtl/pwm_counter.sv
// pwm_counter: free-running period counter with a wrap pulse on the all-ones count
module pwm_counter
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else        cnt <= cnt + 1'b1;
    assign wrap = &cnt;
endmodule

// File: rtl/pwm_gen.sv
// pwm_gen: single-channel PWM with duty shadowed at each period wrap
module pwm_gen
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH_DEFAULT
) (
    input  logic             CLK,
    input  logic             aRSTin,
    input  logic [WIDTH-1:0] Din,
    output logic             PWM
);
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] duty_q;
    logic             wrap;
    logic             pwm_q;
    pwm_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk  (CLK),
        .rst_n(aRSTin),
        .cnt  (cnt),
        .wrap (wrap)
    );
    always_ff @(posedge CLK or negedge aRSTin)
        if (!aRSTin) begin
            duty_q <= '0;
            pwm_q  <= 1'b0;
        end else begin
            duty_q <= wrap ? Din : duty_q;
            pwm_q  <= cnt < duty_q;
        end
    assign PWM = pwm_q;
endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: randomized and directed checks of pwm_gen against a per-period duty model
module tb_pwm_gen;
    logic       CLK = 1'b0;
    logic       aRSTin = 1'b0;
    logic [7:0] Din = 8'd0;
    logic       PWM;
    int total = 0;
    int bad = 0;
    int k = 0;
    int hi = 0;
    int last_rise = -1;
    logic prev = 1'b0;
    logic measure = 1'b0;
    int duty_hist [0:63];

    pwm_gen #(.WIDTH(8)) dut (
        .CLK   (CLK),
        .aRSTin(aRSTin),
        .Din   (Din),
        .PWM   (PWM)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s k=%0d got=%0d exp=%0d", tag, k, got, exp);
        end
    endtask

    // k counts clock edges since reset release; period p uses the Din seen at edge 256p-1
    task automatic tick();
        logic e;
        @(posedge CLK);
        e = 1'b0;
        if (aRSTin) begin
            if (k % 256 == 255) duty_hist[k / 256 + 1] = int'(Din);
            e = (k % 256) < duty_hist[k / 256];
        end
        @(negedge CLK);
        chk("pwm", {31'd0, PWM}, {31'd0, e});
        if (aRSTin) begin
            hi += int'(PWM);
            if (measure && PWM && !prev) begin
                if (last_rise >= 0) chk("period", k - last_rise, 256);
                last_rise = k;
            end
            prev = PWM;
            if (k % 256 == 255) begin
                chk("high_cnt", hi, duty_hist[k / 256]);
                hi = 0;
            end
            k++;
        end
    endtask

    task automatic run(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            tick();
            if (mode == 1) Din = (Din == 8'd10) ? 8'd200 : 8'd10;
            else if (mode == 2) Din = 8'($urandom);
        end
    endtask

    task automatic model_reset();
        aRSTin = 1'b0;
        k = 0;
        hi = 0;
        prev = 1'b0;
        last_rise = -1;
        for (int i = 0; i < 64; i++) duty_hist[i] = 0;
    endtask

    initial begin
        model_reset();
        Din = 8'd128;
        repeat (10) tick();
        aRSTin = 1'b1;
        run(100, 0);
        Din = 8'd32;
        run(156 + 3 * 256, 0);
        Din = 8'd64;
        run(512, 0);
        Din = 8'd192;
        run(512, 0);
        Din = 8'd0;
        run(512, 0);
        Din = 8'd255;
        run(512, 0);
        Din = 8'd10;
        run(768, 1);
        run(512, 2);
        Din = 8'd100;
        measure = 1'b1;
        run(1280, 0);
        measure = 1'b0;
        repeat (3) begin
            Din = 8'($urandom);
            run(int'($urandom_range(256, 700)), 0);
        end
        model_reset();
        repeat (2) tick();
        aRSTin = 1'b1;
        Din = 8'd64;
        run(276, 0);
        chk("pre_rst_high", {31'd0, PWM}, 32'd1);
        aRSTin = 1'b0;
        #1;
        chk("async_rst", {31'd0, PWM}, 32'd0);
        model_reset();
        repeat (3) tick();
        aRSTin = 1'b1;
        run(600, 2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
